// File: rtl/node_pkg.sv
// Shared types and packet field positions for the node PE sequencer.
package node_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_W0,
        RX_W1,
        COMPUTE,
        SEND_REQ,
        SEND_DATA
    } state_t;

    localparam int CTRL_ADDSEL_BIT = 0;
    localparam int CTRL_ID_LSB     = 8;
    localparam int CTRL_ID_MSB     = 13;
    localparam int CTRL_DST_LSB    = 16;
    localparam int CTRL_DST_MSB    = 23;

    localparam logic [5:0] SEQ_LEN_SINGLE = 6'd1;

endpackage

// File: rtl/node_pe_sequencer_if.sv
// Router receive/send, PE operand/result and status bundle.
interface node_pe_sequencer_if;
    import node_pkg::*;

    logic        rx_req;
    logic        rx_ack;
    logic [63:0] rx_data;
    logic        rx_data_valid;
    logic [31:0] pe_a;
    logic [31:0] pe_b;
    logic [31:0] pe_c;
    logic        pe_add_sel;
    logic [31:0] pe_result;
    logic        tx_send_req;
    logic        tx_send_ack;
    logic        tx_data_valid;
    logic [31:0] tx_data;
    logic [7:0]  tx_src;
    logic [7:0]  tx_dst;
    logic [5:0]  tx_seq_len;
    logic [5:0]  tx_id;
    logic        busy;
    logic [15:0] done_cnt;
    logic        err_timeout;

    modport master (
        input  rx_req, rx_data, rx_data_valid, pe_result, tx_send_ack,
        output rx_ack, pe_a, pe_b, pe_c, pe_add_sel,
        output tx_send_req, tx_data_valid, tx_data, tx_src, tx_dst,
        output tx_seq_len, tx_id, busy, done_cnt, err_timeout
    );

    modport slave (
        output rx_req, rx_data, rx_data_valid, pe_result, tx_send_ack,
        input  rx_ack, pe_a, pe_b, pe_c, pe_add_sel,
        input  tx_send_req, tx_data_valid, tx_data, tx_src, tx_dst,
        input  tx_seq_len, tx_id, busy, done_cnt, err_timeout
    );

endinterface

// File: rtl/node_pe_sequencer.sv
// Node controller: receive operand packet, run PE, send result.
// Optional watchdog enabled by NODE_SEQ_TIMEOUT_EN.
module node_pe_sequencer
    import node_pkg::*;
#(
    parameter int         PE_LATENCY  = 4,
    parameter logic [7:0] LOCAL_ID    = 8'h00,
    parameter logic [7:0] DEFAULT_DST = 8'h00,
    parameter int         TIMEOUT_CYC = 255
) (
    input logic N_clk,
    input logic N_rst,
    node_pe_sequencer_if.master bus
);

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        ld_w0, ld_w1, cap, fin;
    logic [31:0] a_stage, b_stage;
    logic [31:0] pe_a_q, pe_b_q, pe_c_q;
    logic        sel_q;
    logic [7:0]  dst_q;
    logic [5:0]  id_q;
    logic [3:0]  lat_cnt;
    logic [31:0] res_q;
    logic [15:0] done_q;
    logic [7:0]  dst_fld;
    logic        to_hit;
    logic        err_q;

    assign dst_fld = bus.rx_data[CTRL_DST_MSB:CTRL_DST_LSB];

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        ld_w0   = 1'b0;
        ld_w1   = 1'b0;
        cap     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_req) begin
                    ack_d   = 1'b1;
                    state_d = RX_W0;
                end
            end
            // the ack cycle itself never accepts a word
            RX_W0: begin
                if (bus.rx_data_valid && !ack_q) begin
                    ld_w0   = 1'b1;
                    state_d = RX_W1;
                end
            end
            RX_W1: begin
                if (bus.rx_data_valid) begin
                    ld_w1   = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (lat_cnt == 4'd1) begin
                    cap     = 1'b1;
                    state_d = SEND_REQ;
                end
            end
            SEND_REQ: begin
                if (bus.tx_send_ack) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (to_hit) state_d = IDLE;
    end

`ifdef NODE_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        wd_state;

    assign wd_state = (state_q == RX_W0) || (state_q == RX_W1) ||
                      (state_q == SEND_REQ);

    // fires only when the FSM would otherwise stay put another cycle
    always_comb begin
        to_hit = 1'b0;
        if (wd_state && wd_q == 16'(TIMEOUT_CYC - 1)) begin
            unique case (state_q)
                RX_W0:    to_hit = !(bus.rx_data_valid && !ack_q);
                RX_W1:    to_hit = !bus.rx_data_valid;
                SEND_REQ: to_hit = !bus.tx_send_ack;
                default:  to_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) wd_q <= '0;
            else if (wd_state)      wd_q <= wd_q + 16'd1;
            if (to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err_q  = 1'b0;
`endif

    always_ff @(posedge N_clk or posedge N_rst) begin
        if (N_rst) begin
            ack_q   <= 1'b0;
            a_stage <= '0;
            b_stage <= '0;
            pe_a_q  <= '0;
            pe_b_q  <= '0;
            pe_c_q  <= '0;
            sel_q   <= 1'b0;
            dst_q   <= '0;
            id_q    <= '0;
            lat_cnt <= '0;
            res_q   <= '0;
            done_q  <= '0;
        end else begin
            ack_q <= ack_d;
            if (ld_w0) begin
                a_stage <= bus.rx_data[63:32];
                b_stage <= bus.rx_data[31:0];
            end
            if (ld_w1) begin
                pe_a_q  <= a_stage;
                pe_b_q  <= b_stage;
                pe_c_q  <= bus.rx_data[63:32];
                sel_q   <= bus.rx_data[CTRL_ADDSEL_BIT];
                id_q    <= bus.rx_data[CTRL_ID_MSB:CTRL_ID_LSB];
                dst_q   <= (dst_fld == 8'h00) ? DEFAULT_DST : dst_fld;
                lat_cnt <= 4'(PE_LATENCY);
            end else if (state_q == COMPUTE) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (cap) res_q  <= bus.pe_result;
            if (fin) done_q <= done_q + 16'd1;
        end
    end

    assign bus.rx_ack        = ack_q;
    assign bus.pe_a          = pe_a_q;
    assign bus.pe_b          = pe_b_q;
    assign bus.pe_c          = pe_c_q;
    assign bus.pe_add_sel    = sel_q;
    assign bus.tx_send_req   = (state_q == SEND_REQ);
    assign bus.tx_data_valid = (state_q == SEND_DATA);
    assign bus.tx_data       = (state_q == SEND_DATA) ? res_q : 32'h0;
    assign bus.tx_src        = LOCAL_ID;
    assign bus.tx_dst        = dst_q;
    assign bus.tx_seq_len    = SEQ_LEN_SINGLE;
    assign bus.tx_id         = id_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done_cnt      = done_q;
    assign bus.err_timeout   = err_q;

endmodule
